// File: rtl/pio_irq_servicer_pkg.sv
// Shared definitions for the PIO pen-IRQ servicer: state encodings and PIO register map.
// State codes are plain 4-bit constants so they line up with older netlists and debug captures.
package pio_irq_servicer_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_ARM         = 4'd0;
    localparam state_t ST_IDLE        = 4'd1;
    localparam state_t ST_MASK        = 4'd2;
    localparam state_t ST_DEBOUNCE    = 4'd3;
    localparam state_t ST_RD_CONFIRM  = 4'd4;
    localparam state_t ST_CAP_CONFIRM = 4'd5;
    localparam state_t ST_POLL_WAIT   = 4'd6;
    localparam state_t ST_RD_POLL     = 4'd7;
    localparam state_t ST_CAP_POLL    = 4'd8;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;

    // States in which the servicer owns a bus transaction.
    function automatic logic drives_bus(input state_t s);
        return (s == ST_ARM) || (s == ST_MASK) || (s == ST_RD_CONFIRM) || (s == ST_RD_POLL);
    endfunction

    // States in which that transaction is a write to irq_mask.
    function automatic logic writes_mask(input state_t s);
        return (s == ST_ARM) || (s == ST_MASK);
    endfunction

endpackage

// File: rtl/pio_irq_wait_timer.sv
// Loadable down-counter shared by the debounce and release-poll waits.
// Holds at zero; only a load moves it away from zero, so it never wraps.
module pio_irq_wait_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/pio_irq_servicer.sv
// Hardware servicer for the pen-IRQ input PIO: arm, mask, debounce, confirm, poll for release.
// Optional PIO_IRQ_SERVICER_EVENT_COUNT_EN adds saturating event_count / glitch_count outputs.
module pio_irq_servicer
    import pio_irq_servicer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int POLL_CYCLES     = 100,
    parameter int CNT_W           = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        irq,
    output logic [1:0]  address,
    output logic        chipselect,
    output logic        write_n,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    output logic        level_assert,
    output logic        level_release,
    output logic        level_state,
    output logic        busy,
`ifdef PIO_IRQ_SERVICER_EVENT_COUNT_EN
    output logic [15:0] event_count,
    output logic [15:0] glitch_count,
`endif
    output logic [3:0]  dbg_state
);

    localparam logic [CNT_W-1:0] DEB_LOAD  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] POLL_LOAD = CNT_W'(POLL_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_value;
    logic             tmr_dec;
    logic [CNT_W-1:0] tmr_count;
    logic             tmr_done;
    logic             rd_bit;
    logic             confirm_hit;
    logic             confirm_glitch;
    logic             poll_low;

    assign rd_bit         = readdata[0];
    assign confirm_hit    = (state == ST_CAP_CONFIRM) && rd_bit;
    assign confirm_glitch = (state == ST_CAP_CONFIRM) && !rd_bit;
    assign poll_low       = (state == ST_CAP_POLL) && !rd_bit;
    assign dbg_state      = state;

    pio_irq_wait_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .dec        (tmr_dec),
        .count      (tmr_count),
        .done       (tmr_done)
    );

    always_comb begin
        next_state     = state;
        tmr_load       = 1'b0;
        tmr_load_value = POLL_LOAD;
        tmr_dec        = 1'b0;
        case (state)
            // Bus outputs are registered from next_state, so after reset the unmask
            // write lands one cycle later; leave ARM once it is actually on the bus.
            ST_ARM:         if (chipselect && !write_n) next_state = ST_IDLE;
            ST_IDLE:        if (irq) next_state = ST_MASK;
            ST_MASK: begin
                next_state     = ST_DEBOUNCE;
                tmr_load       = 1'b1;
                tmr_load_value = DEB_LOAD;
            end
            ST_DEBOUNCE: begin
                if (tmr_done) next_state = ST_RD_CONFIRM;
                else          tmr_dec    = 1'b1;
            end
            ST_RD_CONFIRM:  next_state = ST_CAP_CONFIRM;
            ST_CAP_CONFIRM: begin
                if (rd_bit) begin
                    next_state = ST_POLL_WAIT;
                    tmr_load   = 1'b1;
                end else begin
                    next_state = ST_ARM;
                end
            end
            ST_POLL_WAIT: begin
                if (tmr_done) next_state = ST_RD_POLL;
                else          tmr_dec    = 1'b1;
            end
            ST_RD_POLL:     next_state = ST_CAP_POLL;
            ST_CAP_POLL: begin
                if (!rd_bit) begin
                    next_state = ST_ARM;
                end else begin
                    next_state = ST_POLL_WAIT;
                    tmr_load   = 1'b1;
                end
            end
            default:        next_state = ST_ARM;
        endcase
    end

    // Outputs are registered against next_state so the bus cycle coincides with its state;
    // a read issued in RD_* therefore returns data in the matching CAP_* state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_ARM;
            chipselect    <= 1'b0;
            write_n       <= 1'b1;
            address       <= ADDR_DATA;
            writedata     <= '0;
            level_assert  <= 1'b0;
            level_release <= 1'b0;
            level_state   <= 1'b0;
            busy          <= 1'b1;
        end else begin
            state         <= next_state;
            chipselect    <= drives_bus(next_state);
            write_n       <= !writes_mask(next_state);
            address       <= writes_mask(next_state) ? ADDR_MASK : ADDR_DATA;
            writedata     <= {31'd0, next_state == ST_ARM};
            level_assert  <= confirm_hit;
            level_release <= poll_low;
            if (confirm_hit)   level_state <= 1'b1;
            else if (poll_low) level_state <= 1'b0;
            busy          <= (next_state != ST_IDLE);
        end
    end

`ifdef PIO_IRQ_SERVICER_EVENT_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            event_count  <= '0;
            glitch_count <= '0;
        end else begin
            if (confirm_hit && (event_count != 16'hFFFF))     event_count  <= event_count + 16'd1;
            if (confirm_glitch && (glitch_count != 16'hFFFF)) glitch_count <= glitch_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/pio_irq_servicer.md
Name: pio_irq_servicer

Overview:
- Avalon-MM master that drives the slave side of the single-bit input PIO (the touch panel pen IRQ PIO).
- The slave exposes data at word address 0 and irq_mask at word address 2. Reads are registered: readdata is valid exactly one clk after address is presented. There is no waitrequest.
- The block arms the PIO interrupt, services it in hardware (mask, debounce, confirm read) and polls for release before re-arming.
- It emits clean assert/release pulses to downstream logic, so no CPU ISR is needed.

Parameters:
- DEBOUNCE_CYCLES, 1000: clk cycles to wait after masking before the confirm read (min 1).
- POLL_CYCLES, 100: clk cycles between release-poll reads (min 1).
- CNT_W, 16: width of the internal wait counter; must hold max(DEBOUNCE_CYCLES, POLL_CYCLES).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- irq  in  1  PIO interrupt (data_in & irq_mask)
- address  out  2  Avalon word address to PIO
- chipselect  out  1  Avalon chipselect
- write_n  out  1  Avalon write strobe, active-low
- writedata  out  32  Avalon write data
- readdata  in  32  Avalon read data; only bit 0 is used
- level_assert  out  1  one-cycle pulse: input confirmed high
- level_release  out  1  one-cycle pulse: input confirmed low after an assert
- level_state  out  1  debounced input level
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - chipselect=0, write_n=1, address=0, writedata=0.
  - level_assert=0, level_release=0, level_state=0, counter=0.
  - FSM enters ARM.
- An Avalon write is a single cycle: chipselect=1, write_n=0, address, writedata. No waitrequest.
- An Avalon read is chipselect=1, write_n=1, address=0 for one cycle; readdata[0] is sampled on the following cycle.
- All outputs are registered.
- States and transitions:
  - ARM: write addr 2, data 1 (unmask) -> IDLE.
  - IDLE: busy=0. If irq=1 -> MASK.
  - MASK: write addr 2, data 0 -> DEBOUNCE; load counter = DEBOUNCE_CYCLES-1.
  - DEBOUNCE: decrement counter; at 0 -> RD_CONFIRM.
  - RD_CONFIRM: issue read of addr 0 -> CAP_CONFIRM.
  - CAP_CONFIRM:
    - If readdata[0]=1: level_state<=1, pulse level_assert, counter<=POLL_CYCLES-1 -> POLL_WAIT.
    - Else (glitch): no pulse -> ARM.
  - POLL_WAIT: decrement counter; at 0 -> RD_POLL.
  - RD_POLL: issue read of addr 0 -> CAP_POLL.
  - CAP_POLL:
    - If readdata[0]=0: level_state<=0, pulse level_release -> ARM.
    - Else: reload counter -> POLL_WAIT.
- Latency:
  - irq rising in IDLE to level_assert pulse = DEBOUNCE_CYCLES+4 clk.
  - irq is ignored in every state except IDLE.
  - ARM to IDLE is 1 cycle. An irq already high on entry to IDLE re-triggers MASK on the next cycle.
- The bus is idle (chipselect=0) in every state except ARM, MASK, RD_*.
- Reset mid-operation returns to ARM with all outputs at reset values; no release pulse is generated.
- The counter never wraps: reload happens only on exit from a wait state.
- level_assert and level_release are never high in the same cycle.

Optional Feature:
- Macro PIO_IRQ_SERVICER_EVENT_COUNT_EN.
- When defined:
  - Adds output port event_count [15:0], reset 0.
  - event_count increments on each level_assert and saturates at 16'hFFFF.
  - Adds glitch_count [15:0], incremented on the CAP_CONFIRM glitch path, also saturating.
- When undefined: both ports and both counters are absent; behaviour is otherwise identical.

Decomposition:
- Package pio_irq_servicer_pkg holds:
  - the state enum (ARM, IDLE, MASK, DEBOUNCE, RD_CONFIRM, CAP_CONFIRM, POLL_WAIT, RD_POLL, CAP_POLL);
  - localparams ADDR_DATA=2'd0 and ADDR_MASK=2'd2.
- One sub-module, pio_irq_wait_timer: loadable down-counter with a done flag, shared by DEBOUNCE and POLL_WAIT.

Test Plan:
- Reset release, with a PIO slave model attached:
  - First cycle: exactly one write to addr 2 with data 1, then busy=0.
  - Slave irq_mask reads back 1.
- DEBOUNCE_CYCLES=4, POLL_CYCLES=3, in_port held 1 from cycle 10:
  - Mask write of 0 occurs at cycle 11.
  - level_assert pulses once at cycle 18.
  - level_state=1.
  - Reads of addr 0 repeat every 5 cycles.
- Continuing the previous case, in_port drops to 0:
  - Exactly one level_release at the next CAP_POLL.
  - Unmask write follows one cycle later.
  - level_state=0.
- Glitch, in_port high for 2 cycles only:
  - No level_assert.
  - Mask rewritten to 1.
  - glitch_count=1 with the macro defined.
- Assert reset_n=0 during POLL_WAIT:
  - All outputs return to reset values immediately (asynchronously).
  - No level_release pulse.
  - Re-arm write occurs after reset release.
- With the macro defined, 3 clean press/release cycles:
  - event_count=3.
  - Separately, event_count forced to 16'hFFFF stays at 16'hFFFF after a further assert.
